// File: rtl/qcw_pkg.sv
// Shared definitions for the QCW cycle sequencer: register map, STATUS/CTRL bit positions,
// FSM state encoding and timing constants. STATUS bit indices match the ramp controller's
// offsets file so both ends decode the same word.
package qcw_pkg;

  // Byte offsets inside the 5-word register window.
  localparam logic [4:0]  OFF_CTRL        = 5'd0;
  localparam logic [4:0]  OFF_STATUS      = 5'd4;
  localparam logic [4:0]  OFF_PERIOD      = 5'd8;
  localparam logic [4:0]  OFF_MAX_CYCLES  = 5'd12;
  localparam logic [4:0]  OFF_CYCLE_COUNT = 5'd16;
  localparam logic [31:0] WINDOW_BYTES    = 32'd20;

  localparam int unsigned CTRL_FIRE  = 0;
  localparam int unsigned CTRL_ABORT = 1;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_HALT  = 1;
  localparam int unsigned STAT_LIMIT = 2;
  localparam int unsigned STAT_ABORT = 3;

  localparam logic [15:0] MIN_PERIOD = 16'd16;
  // Done pulse leads the wrap so the ramp controller's reply settles before the phase latch.
  localparam logic [15:0] DONE_LEAD  = 16'd4;

  typedef enum logic [1:0] {StIdle, StStart, StRun, StStop} qcw_state_e;

  function automatic logic [15:0] eff_period(input logic [15:0] period);
    return (period < MIN_PERIOD) ? MIN_PERIOD : period;
  endfunction

endpackage

// File: rtl/qcw_cycle_sequencer_if.sv
// Native memory bus between a bus master and the sequencer's register window.
//   mem_valid_i/addr/wdata/wstrb : request from master (any wstrb bit set = write)
//   mem_ready_o/mem_rdata_o      : one-cycle acknowledge and read data from slave
interface qcw_cycle_sequencer_if;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic [31:0] mem_rdata_o;

  modport master (
    output mem_valid_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
    input  mem_ready_o, mem_rdata_o
  );

  modport slave (
    input  mem_valid_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
    output mem_ready_o, mem_rdata_o
  );
endinterface

// File: rtl/qcw_bridge_timer.sv
// Per-cycle bridge timing: phase counter, leg-B phase shift and leg compares.
//   period  : effective period P (already clamped to MIN_PERIOD)
//   phase   : phase for the next cycle, latched on load and on every wrap
//   load    : clear counter and latch phase (START)
//   run     : advance counter 0..P-1 with wrap
//   legs_en : legs follow the compare; low otherwise (registered, 1-clock latency)
//   leg_a/leg_b, done (count == P-DONE_LEAD), wrap (count == P-1)
module qcw_bridge_timer
  import qcw_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] period,
  input  logic [7:0]  phase,
  input  logic        load,
  input  logic        run,
  input  logic        legs_en,
  output logic        leg_a,
  output logic        leg_b,
  output logic        done,
  output logic        wrap
);

  logic [15:0] count_q, count_d;
  logic [7:0]  phase_q;
  logic        leg_a_q, leg_b_q;
  logic [15:0] half, shift, pos_b;
  logic [23:0] product;
  logic [16:0] sum_b;
  logic        unused_product;

  assign half    = period >> 1;
  assign product = {16'd0, phase_q} * {8'd0, half};
  assign shift   = product[23:8];
  assign unused_product = ^product[7:0];

  // shift < P, so count + P - shift lies in [0, 2P); a single subtract is the modulo.
  assign sum_b = {1'b0, count_q} + {1'b0, period} - {1'b0, shift};
  assign pos_b = (sum_b >= {1'b0, period}) ? 16'(sum_b - {1'b0, period}) : sum_b[15:0];

  assign wrap = run && (count_q == period - 16'd1);
  assign done = run && (count_q == period - DONE_LEAD);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (run) begin
      count_d = wrap ? 16'd0 : count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      phase_q <= '0;
      leg_a_q <= 1'b0;
      leg_b_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (load || wrap) phase_q <= phase;
      leg_a_q <= legs_en && (count_q < half);
      leg_b_q <= legs_en && (pos_b < half);
    end
  end

  assign leg_a = leg_a_q;
  assign leg_b = leg_b_q;

endmodule

// File: rtl/qcw_cycle_sequencer.sv
// Bus-mapped bridge timing generator driving the QCW ramp interface.
//   clk, reset_n             : clock, asynchronous active-low reset
//   bus                      : register window (CTRL, STATUS, PERIOD, MAX_CYCLES, CYCLE_COUNT)
//   qcw_start                : one-cycle pulse at burst start
//   qcw_cycle_done           : one-cycle pulse per resonant cycle (count == P-4)
//   qcw_halt/qcw_phase_value : ramp controller halt request and next-cycle phase
//   leg_a, leg_b             : half-bridge high-side commands
//   busy                     : burst in progress
module qcw_cycle_sequencer
  import qcw_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
  parameter int unsigned RESET_PERIOD     = 400,
  parameter int unsigned RESET_MAX_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  qcw_cycle_sequencer_if.slave        bus,
  output logic                        qcw_start,
  output logic                        qcw_cycle_done,
  input  logic                        qcw_halt,
  input  logic [7:0]                  qcw_phase_value,
  output logic                        leg_a,
  output logic                        leg_b,
  output logic                        busy
);

  qcw_state_e  state_q, state_d;
  logic        hold_q, ready_q;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] period_q, max_q, cycles_q;
  logic [3:1]  cause_q, cause_d;
  logic        halt_pend_q;

  logic [31:0] offset;
  logic        in_win, accept, is_wr, cfg_wr, fire, abort, limit;
  logic        load, run, legs_en, wrap, done;
  logic        unused_wdata;

  // Bus decode: hold_q blocks a second acknowledge until valid drops.
  assign offset = bus.mem_addr_i - BASE_ADDR;
  assign in_win = offset < WINDOW_BYTES;
  assign accept = bus.mem_valid_i && in_win && !hold_q;
  assign is_wr  = |bus.mem_wstrb_i;
  assign cfg_wr = accept && is_wr && (state_q == StIdle);
  assign fire   = accept && is_wr && (offset[4:0] == OFF_CTRL) && bus.mem_wdata_i[CTRL_FIRE];
  assign abort  = accept && is_wr && (offset[4:0] == OFF_CTRL) && bus.mem_wdata_i[CTRL_ABORT];
  assign limit  = (cycles_q == max_q);
  assign unused_wdata = ^bus.mem_wdata_i[31:16];

  always_comb begin
    rdata_d = '0;
    if (accept && !is_wr) begin
      case (offset[4:0])
        OFF_STATUS:      rdata_d = {28'd0, cause_q, state_q != StIdle};
        OFF_PERIOD:      rdata_d = {16'd0, period_q};
        OFF_MAX_CYCLES:  rdata_d = {16'd0, max_q};
        OFF_CYCLE_COUNT: rdata_d = {16'd0, cycles_q};
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q   <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      period_q <= 16'(RESET_PERIOD);
      max_q    <= 16'(RESET_MAX_CYCLES);
    end else begin
      hold_q  <= bus.mem_valid_i && (hold_q || accept);
      ready_q <= accept;
      rdata_q <= rdata_d;
      if (cfg_wr && offset[4:0] == OFF_PERIOD)     period_q <= bus.mem_wdata_i[15:0];
      if (cfg_wr && offset[4:0] == OFF_MAX_CYCLES) max_q    <= bus.mem_wdata_i[15:0];
    end
  end

  assign bus.mem_ready_o = ready_q;
  assign bus.mem_rdata_o = rdata_q;

  // FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fire) state_d = StStart;
      StStart: state_d = StRun;
      StRun:   if (abort || (wrap && (halt_pend_q || limit))) state_d = StStop;
      StStop:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. Legs are cut on the edge that enters STOP, hence the look at state_d.
  always_comb begin
    qcw_start = (state_q == StStart);
    busy      = (state_q != StIdle);
    load      = (state_q == StStart);
    run       = (state_q == StRun);
    legs_en   = (state_q == StRun) && (state_d == StRun);
  end

  // Stop causes: abort wins; halt and limit may both be recorded at the same wrap.
  always_comb begin
    cause_d = cause_q;
    if (state_q == StIdle && fire) begin
      cause_d = '0;
    end else if (state_q == StRun) begin
      if (abort) begin
        cause_d[STAT_ABORT] = 1'b1;
      end else if (wrap) begin
        if (halt_pend_q) cause_d[STAT_HALT]  = 1'b1;
        if (limit)       cause_d[STAT_LIMIT] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q     <= '0;
      cycles_q    <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      cause_q <= cause_d;
      if (load) begin
        cycles_q    <= '0;
        halt_pend_q <= 1'b0;
      end else if (run) begin
        if (done && cycles_q != 16'hFFFF) cycles_q <= cycles_q + 16'd1;
        if (qcw_halt) halt_pend_q <= 1'b1;
      end
    end
  end

  qcw_bridge_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (eff_period(period_q)),
    .phase   (qcw_phase_value),
    .load    (load),
    .run     (run),
    .legs_en (legs_en),
    .leg_a   (leg_a),
    .leg_b   (leg_b),
    .done    (done),
    .wrap    (wrap)
  );

  assign qcw_cycle_done = done;

endmodule

// File: tb/tb_qcw_cycle_sequencer.sv
module tb_qcw_cycle_sequencer;
  import qcw_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       qcw_start, qcw_cycle_done, qcw_halt, leg_a, leg_b, busy;
  logic [7:0] qcw_phase_value;

  always #5 clk = ~clk;

  qcw_cycle_sequencer_if bus_if ();

  qcw_cycle_sequencer #(
    .BASE_ADDR        (BASE),
    .RESET_PERIOD     (400),
    .RESET_MAX_CYCLES (1000)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus_if),
    .qcw_start       (qcw_start),
    .qcw_cycle_done  (qcw_cycle_done),
    .qcw_halt        (qcw_halt),
    .qcw_phase_value (qcw_phase_value),
    .leg_a           (leg_a),
    .leg_b           (leg_b),
    .busy            (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h (%0d), want 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard: every bus access pushes its expected read data (0 for writes).
  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk) begin
    if (reset_n && bus_if.mem_ready_o) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got ready with rdata 0x%0h, want no ready", bus_if.mem_rdata_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, bus_if.mem_rdata_o, e.exp);
      end
    end
  end

  // Burst monitor: offsets are clocks since the qcw_start cycle.
  int cyc = 0;
  int start_cyc, busy_cycles, a_hi, b_hi, ab_diff;
  int done_off[$];
  int a_rise[$];
  int b_rise[$];
  logic a_prev, b_prev;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (qcw_start) begin
        start_cyc = cyc; busy_cycles = 0; a_hi = 0; b_hi = 0; ab_diff = 0;
        done_off.delete(); a_rise.delete(); b_rise.delete();
        a_prev = 1'b0; b_prev = 1'b0;
      end
      if (busy) busy_cycles++;
      if (leg_a) a_hi++;
      if (leg_b) b_hi++;
      if (leg_a != leg_b) ab_diff++;
      if (leg_a && !a_prev) a_rise.push_back(cyc - start_cyc);
      if (leg_b && !b_prev) b_rise.push_back(cyc - start_cyc);
      if (qcw_cycle_done) done_off.push_back(cyc - start_cyc);
      a_prev = leg_a;
      b_prev = leg_b;
    end
  end

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Ramp controller model: entries 0, 64, 128; the 4th done pulse raises halt.
  logic ramp_en = 1'b0;
  int   ramp_dones = 0;
  logic [7:0] ramp_tab [3] = '{8'd0, 8'd64, 8'd128};

  always @(negedge clk) begin
    if (ramp_en && qcw_cycle_done) begin
      ramp_dones++;
      if (ramp_dones <= 2) qcw_phase_value = ramp_tab[ramp_dones];
      else if (ramp_dones == 4) qcw_halt = 1'b1;
    end
  end

  // Bus master: called and returns at a negedge; samples legs/busy in the ready cycle.
  task automatic xfer(input string name, input logic [4:0] off, input logic wr,
                      input logic [31:0] val, output logic a_s, output logic b_s,
                      output logic busy_s);
    exp_t e;
    logic got;
    e.name = name;
    e.exp  = wr ? 32'd0 : val;
    sb_q.push_back(e);
    bus_if.mem_addr_i  = BASE + {27'd0, off};
    bus_if.mem_wdata_i = wr ? val : 32'd0;
    bus_if.mem_wstrb_i = wr ? 4'hF : 4'h0;
    bus_if.mem_valid_i = 1'b1;
    got = 1'b0; a_s = 1'b0; b_s = 1'b0; busy_s = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus_if.mem_ready_o) begin
        got = 1'b1; a_s = leg_a; b_s = leg_b; busy_s = busy;
      end
    end
    bus_if.mem_valid_i = 1'b0;
    bus_if.mem_wstrb_i = 4'h0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no mem_ready_o in 8 clocks, want ready", name);
      e = sb_q.pop_back();
    end
    @(negedge clk);
  endtask

  task automatic wr(input string name, input logic [4:0] off, input logic [31:0] val);
    logic a, b, bs;
    xfer(name, off, 1'b1, val, a, b, bs);
  endtask

  task automatic rd(input string name, input logic [4:0] off, input logic [31:0] exp);
    logic a, b, bs;
    xfer(name, off, 1'b0, exp, a, b, bs);
  endtask

  task automatic wait_idle(input string name);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    check(name, 32'(idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a_s, b_s, busy_s, got;
    qcw_halt = 1'b0;
    qcw_phase_value = 8'd0;
    bus_if.mem_valid_i = 1'b0;
    bus_if.mem_addr_i  = '0;
    bus_if.mem_wdata_i = '0;
    bus_if.mem_wstrb_i = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #11;
    check("rst_leg_a", 32'(leg_a), 32'd0);
    check("rst_leg_b", 32'(leg_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(bus_if.mem_ready_o), 32'd0);
    check("rst_start", 32'(qcw_start), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    rd("rst_ctrl", OFF_CTRL, 32'd0);
    rd("rst_status", OFF_STATUS, 32'd0);
    rd("rst_period", OFF_PERIOD, 32'd400);
    rd("rst_max", OFF_MAX_CYCLES, 32'd1000);
    rd("rst_count", OFF_CYCLE_COUNT, 32'd0);
    rd("odd_offset", 5'd2, 32'd0);

    // Burst 1: P=100, phase 0, 3 cycles.
    wr("wr_period", OFF_PERIOD, 32'd100);
    wr("wr_max3", OFF_MAX_CYCLES, 32'd3);
    wr("fire1", OFF_CTRL, 32'd1);
    wait_idle("b1_idle");
    check("b1_busy_cycles", 32'(busy_cycles), 32'd302);
    check("b1_leg_a_high", 32'(a_hi), 32'd150);
    check("b1_leg_b_high", 32'(b_hi), 32'd150);
    check("b1_legs_differ", 32'(ab_diff), 32'd0);
    check("b1_done_pulses", 32'(done_off.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("b1_done_off", 32'(qat(done_off, i)), 32'(97 + 100 * i));
    rd("b1_status", OFF_STATUS, 32'd4);
    rd("b1_count", OFF_CYCLE_COUNT, 32'd3);

    // Phase 128 and 255, single cycle each.
    wr("wr_max1", OFF_MAX_CYCLES, 32'd1);
    qcw_phase_value = 8'd128;
    wr("fire_p128", OFF_CTRL, 32'd1);
    wait_idle("p128_idle");
    check("p128_a_rise", 32'(qat(a_rise, 0)), 32'd2);
    check("p128_shift", 32'(qat(b_rise, 0) - qat(a_rise, 0)), 32'd25);
    qcw_phase_value = 8'd255;
    wr("fire_p255", OFF_CTRL, 32'd1);
    wait_idle("p255_idle");
    check("p255_shift", 32'(qat(b_rise, 0) - qat(a_rise, 0)), 32'd49);
    check("p255_busy_cycles", 32'(busy_cycles), 32'd102);

    // Ramp with 3 entries: 4 cycles, halt stop.
    wr("wr_max1000", OFF_MAX_CYCLES, 32'd1000);
    qcw_phase_value = 8'd0;
    ramp_dones = 0;
    ramp_en = 1'b1;
    wr("fire_ramp", OFF_CTRL, 32'd1);
    wait_idle("ramp_idle");
    ramp_en = 1'b0;
    qcw_halt = 1'b0;
    qcw_phase_value = 8'd0;
    check("ramp_busy_cycles", 32'(busy_cycles), 32'd402);
    check("ramp_a_rises", 32'(a_rise.size()), 32'd4);
    check("ramp_b_rises", 32'(b_rise.size()), 32'd4);
    check("ramp_shift0", 32'(qat(b_rise, 0) - qat(a_rise, 0)), 32'd0);
    check("ramp_shift1", 32'(qat(b_rise, 1) - qat(a_rise, 1)), 32'd12);
    check("ramp_shift2", 32'(qat(b_rise, 2) - qat(a_rise, 2)), 32'd25);
    check("ramp_shift3", 32'(qat(b_rise, 3) - qat(a_rise, 3)), 32'd25);
    rd("ramp_status", OFF_STATUS, 32'd2);
    rd("ramp_count", OFF_CYCLE_COUNT, 32'd4);

    // Abort around count 30 of the third cycle.
    wr("fire_abort", OFF_CTRL, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done_off.size() >= 2) got = 1'b1;
    end
    check("abort_reach_cycle3", 32'(got), 32'd1);
    repeat (32) @(negedge clk);
    check("abort_leg_a_before", 32'(leg_a), 32'd1);
    xfer("abort", OFF_CTRL, 1'b1, 32'd2, a_s, b_s, busy_s);
    check("abort_leg_a_after", 32'(a_s), 32'd0);
    check("abort_leg_b_after", 32'(b_s), 32'd0);
    check("abort_stop_busy", 32'(busy_s), 32'd1);
    check("abort_idle", 32'(busy), 32'd0);
    rd("abort_status", OFF_STATUS, 32'd8);
    rd("abort_count", OFF_CYCLE_COUNT, 32'd2);

    // PERIOD=5 clamps to 16; config writes while busy are ignored.
    wr("wr_period5", OFF_PERIOD, 32'd5);
    rd("rd_period5", OFF_PERIOD, 32'd5);
    wr("wr_max2", OFF_MAX_CYCLES, 32'd2);
    wr("fire_p16", OFF_CTRL, 32'd1);
    wr("wr_period_busy", OFF_PERIOD, 32'd77);
    wr("wr_max_busy", OFF_MAX_CYCLES, 32'd9);
    rd("rd_period_busy", OFF_PERIOD, 32'd5);
    rd("rd_status_busy", OFF_STATUS, 32'd1);
    wait_idle("p16_idle");
    check("p16_busy_cycles", 32'(busy_cycles), 32'd34);
    check("p16_leg_a_high", 32'(a_hi), 32'd16);
    check("p16_done0", 32'(qat(done_off, 0)), 32'd13);
    check("p16_done1", 32'(qat(done_off, 1)), 32'd29);
    rd("p16_max", OFF_MAX_CYCLES, 32'd2);
    rd("p16_status", OFF_STATUS, 32'd4);

    // Async reset mid-RUN with an acknowledge in flight.
    wr("wr_period100", OFF_PERIOD, 32'd100);
    wr("wr_max_big", OFF_MAX_CYCLES, 32'd1000);
    wr("fire_rst", OFF_CTRL, 32'd1);
    repeat (40) @(negedge clk);
    bus_if.mem_addr_i  = BASE + {27'd0, OFF_PERIOD};
    bus_if.mem_wstrb_i = 4'h0;
    bus_if.mem_valid_i = 1'b1;
    @(posedge clk);
    #1;
    check("arst_ready_before", 32'(bus_if.mem_ready_o), 32'd1);
    check("arst_leg_a_before", 32'(leg_a), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_leg_a", 32'(leg_a), 32'd0);
    check("arst_leg_b", 32'(leg_b), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(bus_if.mem_ready_o), 32'd0);
    bus_if.mem_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd("arst_period", OFF_PERIOD, 32'd400);
    rd("arst_max", OFF_MAX_CYCLES, 32'd1000);
    rd("arst_status", OFF_STATUS, 32'd0);
    rd("arst_count", OFF_CYCLE_COUNT, 32'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qcw_cycle_sequencer.md
# qcw_cycle_sequencer

Bus-mapped bridge timing generator; the driving end of the QCW ramp interface. Generates the two half-bridge gate commands for each resonant cycle, issues `qcw_start` and per-cycle `qcw_cycle_done` to the ramp controller, and applies its `qcw_phase_value` as the leg-B phase shift. Stops on `qcw_halt`, on a cycle limit, or on bus abort. Sits on the same native memory bus as the ramp controller.

## Interface
- `BASE_ADDR`, 32'h00000000, byte base of the 5-word register window.
- `RESET_PERIOD`, 400, reset value of PERIOD in clocks.
- `RESET_MAX_CYCLES`, 1000, reset value of MAX_CYCLES.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_valid_i`  in  1  bus request.
- `mem_ready_o`  out  1  one-cycle acknowledge.
- `mem_addr_i`  in  32  byte address.
- `mem_wdata_i`  in  32  write data.
- `mem_wstrb_i`  in  4  byte strobes; any set bit means write.
- `mem_rdata_o`  out  32  read data, 0 when not acknowledging.
- `qcw_start`  out  1  one-cycle pulse at burst start.
- `qcw_cycle_done`  out  1  one-cycle pulse per resonant cycle.
- `qcw_halt`  in  1  ramp FIFO exhausted; finish current cycle and stop.
- `qcw_phase_value`  in  8  phase for the next cycle, 0 = in phase.
- `leg_a`, `leg_b`  out  1 each  half-bridge high-side commands.
- `busy`  out  1  burst in progress.

## Operation
- Registers at BASE_ADDR+: 0 CTRL (W bit0 FIRE, bit1 ABORT; reads 0); 4 STATUS (R bit0 busy, bit1 stop-by-halt, bit2 stop-by-limit, bit3 stop-by-abort; cause bits sticky, cleared on FIRE); 8 PERIOD (RW [15:0]); 12 MAX_CYCLES (RW [15:0]); 16 CYCLE_COUNT (R [15:0]). Other in-window offsets read 0 and ignore writes.
- Bus: the first cycle `mem_valid_i` is high with an in-window address registers the access. `mem_ready_o` is high for exactly the next cycle, with `mem_rdata_o`, and does not repeat until valid drops. PERIOD/MAX_CYCLES writes are ignored while busy.
- Effective period P = max(PERIOD, 16). Half H = P>>1.
- FSM: IDLE, START, RUN, STOP.
  - IDLE→START on FIRE. START lasts 1 cycle: pulse `qcw_start`, clear CYCLE_COUNT and phase counter, latch phase.
  - START→RUN.
  - RUN→STOP at the end of a cycle (count==P-1) when halt_pending, or when CYCLE_COUNT==MAX_CYCLES, or immediately on ABORT.
  - STOP: 1 cycle, legs low, set cause bit, then IDLE.
  - FIRE outside IDLE is ignored. ABORT in IDLE is ignored.
- Phase counter `count` runs 0..P-1 in RUN and wraps.
  - `leg_a` = (count < H).
  - shift = (phase_latched × H) >> 8, using a 24-bit product.
  - `leg_b` = (((count + P − shift) mod P) < H).
- `qcw_cycle_done` pulses at count==P-4. CYCLE_COUNT increments on the same edge, saturating at 0xFFFF.
- `qcw_halt` sampled high anywhere in RUN sets halt_pending; it is cleared in START.
- Phase is latched at START and on every wrap (P-1→0).
- Causes: if the limit and halt are both true at the same wrap, set both bits. ABORT takes precedence and also sets its bit.

## Timing
- Reset: all outputs 0, FSM IDLE, PERIOD=RESET_PERIOD, MAX_CYCLES=RESET_MAX_CYCLES, STATUS=0.
- Legs are registered outputs, 1-clock latency from `count`.
- The ramp controller returns the next phase ≤3 clocks after `qcw_cycle_done` and halt 1 clock after it. Pulsing at P-4 guarantees both are settled before the wrap latch.
- An N-entry ramp FIFO yields N+1 cycles: the last cycle reuses the stale phase, and halt arrives at its done pulse.
- Legs go low on the STOP entry edge, including mid-cycle abort.
- Async reset mid-burst: legs drop immediately, no STOP cycle, cause bits cleared.

## Structure
- `qcw_pkg`:
  - register offsets, FSM state enum, MIN_PERIOD=16, DONE_LEAD=4
  - STATUS bit indices, shared with the ramp controller's offsets file.
- Sub-module `qcw_bridge_timer`: holds the phase counter, shift multiply, and leg compare. Inputs are P, phase, and run/load; outputs are legs, the done strobe, and the wrap strobe. The top holds the bus, registers, and FSM.

## Test plan
- PERIOD=100, phase 0, MAX_CYCLES=3, FIRE → `leg_a`=`leg_b` square 50/50, three done pulses at counts 96 of each cycle, STATUS=0b0100, busy low after one STOP cycle.
- PERIOD=100, phase 128 → `leg_b` rising edge 25 clocks after `leg_a` rising edge; phase 255 → 49 clocks.
- Ramp model with 3 entries (0, 64, 128), MAX_CYCLES=1000 → 4 cycles with shifts 0, 12, 25, 25; STATUS=0b0010.
- ABORT written at count 30 of cycle 2 → legs low the next clock, STATUS bit3 set, CYCLE_COUNT=2.
- PERIOD=5 → effective P=16, H=8. PERIOD write while busy → register unchanged on readback.
- `reset_n` low mid-RUN → legs, busy, and `mem_ready_o` 0 asynchronously. Registers return to reset values.
